sc_io_in: RTL and testbench

SC_IO_IN -- requirements
Module: sc_io_in

---
 rtl/sc_io_in.sv | 174 +++++++++++++++++
 tb/tb_sc_io_in.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sc_io_in.sv
// Switch/key input block: synchronizes raw switches and a pushbutton, debounces the key,
// latches an operand pair on each accepted press and exposes it through a small read port.
//
// state        | meaning
// -------------+------------------------------------------------------------
// IDLE         | key released and stable, waiting for a press
// PRESS_WAIT   | key seen low, counting stable low samples before capture
// HELD         | press accepted (capture done), waiting for release
// RELEASE_WAIT | key seen high, counting stable high samples before re-arming
module sc_io_in #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  sw,
  input  logic        key,
  input  logic        rd_en,
  input  logic [1:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic [3:0]  one,
  output logic [3:0]  two,
  output logic        valid
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;

  logic [7:0]  sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
  logic        key_s1_q, key_s1_d, key_s2_q, key_s2_d;

  logic [3:0]  one_q, one_d, two_q, two_d;
  logic        valid_q, valid_d, overrun_q, overrun_d;
  logic [7:0]  count_q, count_d;
  logic [31:0] rd_data_q, rd_data_d;

  logic        capture;
  logic        rd_clear;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sw_s1_q   <= '0;
      sw_s2_q   <= '0;
      key_s1_q  <= 1'b1;
      key_s2_q  <= 1'b1;
      one_q     <= '0;
      two_q     <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sw_s1_q   <= sw_s1_d;
      sw_s2_q   <= sw_s2_d;
      key_s1_q  <= key_s1_d;
      key_s2_q  <= key_s2_d;
      one_q     <= one_d;
      two_q     <= two_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
    end
  end

  always_comb begin
    sw_s1_d  = sw;
    sw_s2_d  = sw_s1_q;
    key_s1_d = key;
    key_s2_d = key_s1_q;
  end

  assign cnt_inc = cnt_q + CNT_ONE;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (!key_s2_q) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (key_s2_q) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_LAST) begin
            state_d = HELD;
            capture = 1'b1;
          end
        end
      end
      HELD: begin
        if (key_s2_q) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (!key_s2_q) begin
          state_d = HELD;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign rd_clear = rd_en && (rd_addr == 2'd1);

  // A capture landing on the same edge as a consuming read wins for valid,
  // but the old pair counts as consumed, so no overrun is flagged.
  always_comb begin
    one_d     = one_q;
    two_d     = two_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    count_d   = count_q;
    if (rd_clear) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
    if (capture) begin
      one_d     = sw_s2_q[3:0];
      two_d     = sw_s2_q[7:4];
      valid_d   = 1'b1;
      overrun_d = valid_q && !rd_clear;
      count_d   = count_q + 8'd1;
    end
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      case (rd_addr)
        2'd0:    rd_data_d = {28'b0, one_q};
        2'd1:    rd_data_d = {28'b0, two_q};
        2'd2:    rd_data_d = {30'b0, overrun_q, valid_q};
        default: rd_data_d = {24'b0, count_q};
      endcase
    end
  end

  assign rd_data = rd_data_q;
  assign one     = one_q;
  assign two     = two_q;
  assign valid   = valid_q;

endmodule

// File: tb/tb_sc_io_in.sv
// Bench for sc_io_in: directed press/glitch/overrun/reset/wrap scenarios plus randomized
// presses, all checked against a press-level reference model of the captured state.
module tb_sc_io_in;

  localparam int D = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  sw;
  logic        key;
  logic        rd_en;
  logic [1:0]  rd_addr;
  logic [31:0] rd_data;
  logic [3:0]  one;
  logic [3:0]  two;
  logic        valid;

  int n_checks = 0;
  int n_errors = 0;

  // reference model of the visible register state
  logic [3:0]  m_one, m_two;
  logic        m_valid, m_ovr;
  logic [7:0]  m_cnt;
  logic [31:0] last_rd;

  sc_io_in #(.DEBOUNCE_CYCLES(D), .CNT_W(5)) dut (
    .clock   (clock),
    .reset   (reset),
    .sw      (sw),
    .key     (key),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .one     (one),
    .two     (two),
    .valid   (valid)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model_reset();
    m_one = '0; m_two = '0; m_valid = 1'b0; m_ovr = 1'b0; m_cnt = '0; last_rd = '0;
  endtask

  task automatic model_capture(input logic [7:0] swv);
    if (m_valid) m_ovr = 1'b1;
    m_one   = swv[3:0];
    m_two   = swv[7:4];
    m_valid = 1'b1;
    m_cnt   = m_cnt + 8'd1;
  endtask

  function automatic logic [31:0] model_rd(input logic [1:0] a);
    case (a)
      2'd0:    return {28'b0, m_one};
      2'd1:    return {28'b0, m_two};
      2'd2:    return {30'b0, m_ovr, m_valid};
      default: return {24'b0, m_cnt};
    endcase
  endfunction

  task automatic rd(input logic [1:0] a, input string tag);
    logic [31:0] exp;
    exp = model_rd(a);
    rd_en = 1'b1; rd_addr = a;
    tick();
    rd_en = 1'b0;
    check(tag, rd_data, exp);
    last_rd = exp;
    if (a == 2'd1) begin
      m_valid = 1'b0;
      m_ovr   = 1'b0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    model_reset();
  endtask

  task automatic check_outs(input string tag);
    check({tag, "_one"},   {28'b0, one},   {28'b0, m_one});
    check({tag, "_two"},   {28'b0, two},   {28'b0, m_two});
    check({tag, "_valid"}, {31'b0, valid}, {31'b0, m_valid});
  endtask

  // Key low for low1 samples, optional high bounce, low again, then released for gap.
  // A press is accepted iff the first low stretch lasts at least D cycles.
  task automatic press(input logic [7:0] swv, input int low1, input int bh,
                       input int low2, input int gap);
    sw = swv;
    repeat (4) tick();
    key = 1'b0;
    repeat (low1) tick();
    if (bh > 0) begin
      key = 1'b1;
      repeat (bh) tick();
      key = 1'b0;
      repeat (low2) tick();
    end
    key = 1'b1;
    repeat (gap) tick();
    if (low1 >= D) model_capture(swv);
  endtask

  initial begin
    logic [3:0] old_two;
    reset = 1'b1; sw = '0; key = 1'b1; rd_en = 1'b0; rd_addr = '0;
    model_reset();
    do_reset();

    check("reset_rd_data", rd_data, 32'h0);
    check_outs("reset");
    rd(2'd3, "reset_count");

    // glitches shorter than the debounce window must be ignored
    for (int i = 0; i < 10; i++) press(8'hFF, 5, 0, 0, 5);
    check_outs("glitch");
    rd(2'd3, "glitch_count");

    // single long press: capture lands D+2 edges after key falls
    sw = 8'h3A;
    repeat (4) tick();
    key = 1'b0;
    repeat (D + 1) tick();
    check("press_early_valid", {31'b0, valid}, 32'h0);
    tick();
    check("press_valid", {31'b0, valid}, 32'h1);
    check("press_one", {28'b0, one}, 32'hA);
    check("press_two", {28'b0, two}, 32'h3);
    repeat (40 - (D + 2)) tick();
    key = 1'b1;
    repeat (D + 6) tick();
    model_capture(8'h3A);
    check_outs("press_after");
    rd(2'd0, "press_rd_one");
    rd(2'd3, "press_rd_count");
    rd(2'd2, "press_rd_status");
    repeat (5) tick();
    check("rd_hold", rd_data, last_rd);

    // overrun, then consume
    do_reset();
    press(8'h12, D + 4, 0, 0, D + 6);
    press(8'h34, D + 4, 0, 0, D + 6);
    rd(2'd2, "ovr_status");
    check("ovr_status_const", last_rd, 32'h3);
    rd(2'd1, "ovr_rd_two");
    check("ovr_rd_two_const", last_rd, 32'h3);
    rd(2'd2, "ovr_status_cleared");
    check("ovr_status_cleared_const", last_rd, 32'h0);

    // consuming read on the exact capture edge
    press(8'h5C, D + 4, 0, 0, D + 6);
    old_two = m_two;
    sw = 8'h96;
    repeat (4) tick();
    key = 1'b0;
    repeat (D + 1) tick();
    rd_en = 1'b1; rd_addr = 2'd1;
    tick();
    rd_en = 1'b0;
    check("simul_rd_old_two", rd_data, {28'b0, old_two});
    m_one = 4'h6; m_two = 4'h9; m_valid = 1'b1; m_ovr = 1'b0; m_cnt = m_cnt + 8'd1;
    check_outs("simul");
    repeat (10) tick();
    key = 1'b1;
    repeat (D + 6) tick();
    rd(2'd2, "simul_status");
    rd(2'd3, "simul_count");

    // reset in the middle of PRESS_WAIT abandons the press
    sw = 8'hC7;
    repeat (4) tick();
    key = 1'b0;
    repeat (13) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    check_outs("midrst");
    check("midrst_rd_data", rd_data, 32'h0);
    repeat (D + 1) tick();
    check("midrst_early_valid", {31'b0, valid}, 32'h0);
    tick();
    model_capture(8'hC7);
    check_outs("midrst_capture");
    key = 1'b1;
    repeat (D + 6) tick();
    rd(2'd3, "midrst_count");

    // randomized presses: short glitches, long presses, bounces while held
    for (int i = 0; i < 40; i++) begin
      logic [7:0] swv;
      int low1, bh, low2, gap;
      swv  = 8'($urandom);
      bh   = 0;
      low2 = 0;
      gap  = $urandom_range(D + 4, 2 * D);
      if ($urandom_range(0, 1) == 1) begin
        low1 = $urandom_range(D + 2, 2 * D);
        if ($urandom_range(0, 1) == 1) begin
          bh   = $urandom_range(1, D - 3);
          low2 = $urandom_range(1, 8);
        end
      end else begin
        low1 = $urandom_range(1, D - 3);
      end
      press(swv, low1, bh, low2, gap);
      check_outs("rand");
      if ($urandom_range(0, 1) == 1) rd(2'($urandom_range(0, 3)), "rand_rd");
    end
    rd(2'd3, "rand_count");
    rd(2'd2, "rand_status");

    // capture counter wraps 255 -> 0
    do_reset();
    for (int i = 0; i < 255; i++) press(8'(i), D + 2, 0, 0, D + 4);
    rd(2'd3, "wrap_255");
    press(8'hE1, D + 2, 0, 0, D + 4);
    rd(2'd3, "wrap_0");
    check("wrap_0_const", last_rd, 32'h0);
    check_outs("wrap");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
